// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display bus.
// Both the scan encoder and the readback decoder import this package so
// the segment table exists in exactly one place.
package seg7_pkg;

    // Active-low segment patterns, bit6 = a ... bit0 = g.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // One-hot digit select values.
    localparam logic [3:0] DIG_UNITS     = 4'b0001;
    localparam logic [3:0] DIG_TENS      = 4'b0010;
    localparam logic [3:0] DIG_HUNDREDS  = 4'b0100;
    localparam logic [3:0] DIG_THOUSANDS = 4'b1000;

    localparam logic [3:0] MASK_FULL     = 4'b1111;
    localparam int unsigned VALUE_W      = 14;
    localparam int unsigned BADCNT_W     = 8;
    localparam logic [7:0]  BADCNT_MAX   = 8'd255;

    // Receive-side frame state.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } seg7_state_e;

    // True when exactly one select line is active.
    function automatic logic is_onehot4(input logic [3:0] sel);
        return (sel != 4'b0000) && ((sel & (sel - 4'b0001)) == 4'b0000);
    endfunction

    // Map a one-hot select to its slot index (units = 0 ... thousands = 3).
    function automatic logic [1:0] sel_to_index(input logic [3:0] sel);
        logic [1:0] idx;
        case (sel)
            DIG_UNITS:     idx = 2'd0;
            DIG_TENS:      idx = 2'd1;
            DIG_HUNDREDS:  idx = 2'd2;
            DIG_THOUSANDS: idx = 2'd3;
            default:       idx = 2'd0;
        endcase
        return idx;
    endfunction

    // acc*10 + digit using shift-add; the caller guarantees acc <= 999.
    function automatic logic [13:0] times10_plus(input logic [13:0] acc,
                                                 input logic [3:0]  digit);
        return (acc << 3) + (acc << 1) + {10'd0, digit};
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from an active-low segment pattern to a BCD digit.
// Blank reads as 0 without error; any unknown pattern reads as 0 with err.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd,
    output logic       o_blank,
    output logic       o_err
);

    // Pattern table lookup; everything not in the table is flagged.
    always_comb begin
        o_bcd   = 4'd0;
        o_blank = 1'b0;
        o_err   = 1'b0;
        case (i_seg)
            SEG_0:     o_bcd = 4'd0;
            SEG_1:     o_bcd = 4'd1;
            SEG_2:     o_bcd = 4'd2;
            SEG_3:     o_bcd = 4'd3;
            SEG_4:     o_bcd = 4'd4;
            SEG_5:     o_bcd = 4'd5;
            SEG_6:     o_bcd = 4'd6;
            SEG_7:     o_bcd = 4'd7;
            SEG_8:     o_bcd = 4'd8;
            SEG_9:     o_bcd = 4'd9;
            SEG_BLANK: o_blank = 1'b1;
            default:   o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Readback decoder for the scanned 7-segment bus: collects one 4-digit
// frame, converts it MSB-first to binary and reports value/error/change.
module seg7_scan_decoder
    import seg7_pkg::*;
(
    input  logic        clk_d,
    input  logic        reset_n,
    input  logic        sample_en,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_in,
    input  logic        clear,
    output logic [13:0] value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        changed,
    output logic [7:0]  bad_sel_cnt
);

    // Decoded view of the bus this cycle.
    logic [3:0] w_bcd;
    logic       w_blank;
    logic       w_err;
    logic       w_sel_ok;
    logic [1:0] w_slot;
    logic       w_take;
    logic [3:0] w_mask_next;

    // Frame state.
    seg7_state_e r_state;
    logic [3:0]  r_mask;
    logic [3:0]  r_digit [0:3];
    logic [3:0]  r_err_slot;
    logic [13:0] r_acc;
    logic [1:0]  r_step;
    logic        r_first;

    // Registered outputs.
    logic [13:0] r_value;
    logic        r_frame_valid;
    logic        r_frame_err;
    logic        r_changed;
    logic [7:0]  r_bad_cnt;

    seg7_pattern_decode u_decode (
        .i_seg   (seg_in),
        .o_bcd   (w_bcd),
        .o_blank (w_blank),
        .o_err   (w_err)
    );

    assign w_sel_ok    = is_onehot4(dig_in);
    assign w_slot      = sel_to_index(dig_in);
    assign w_take      = sample_en & w_sel_ok & ~clear;
    assign w_mask_next = r_mask | dig_in;

    // Count rejected samples with an illegal select, in every state, saturating.
    always_ff @(posedge clk_d or negedge reset_n) begin
        if (!reset_n) begin
            r_bad_cnt <= 8'd0;
        end else if (sample_en && !w_sel_ok && (r_bad_cnt != BADCNT_MAX)) begin
            r_bad_cnt <= r_bad_cnt + 8'd1;
        end else begin
            r_bad_cnt <= r_bad_cnt;
        end
    end

    // Frame FSM: collect four slots, shift-add convert MSB first, publish.
    always_ff @(posedge clk_d or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= COLLECT;
            r_mask        <= 4'b0000;
            r_err_slot    <= 4'b0000;
            r_acc         <= 14'd0;
            r_step        <= 2'd0;
            r_first       <= 1'b1;
            r_value       <= 14'd0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_changed     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_digit[i] <= 4'd0;
            end
        end else begin
            r_frame_valid <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (sample_en && clear) begin
                        r_mask <= 4'b0000;
                    end else if (clear) begin
                        // clear wins over any sample in the same cycle
                        r_mask <= 4'b0000;
                    end else if (w_take) begin
                        r_digit[w_slot]    <= w_bcd;
                        r_err_slot[w_slot] <= w_err;
                        r_mask             <= w_mask_next;
                        if (w_mask_next == MASK_FULL) begin
                            r_state <= CONVERT;
                            r_acc   <= 14'd0;
                            r_step  <= 2'd3;
                        end
                    end
                end
                CONVERT: begin
                    // thousands first; acc never exceeds 999 before the last step
                    r_acc <= times10_plus(r_acc, r_digit[r_step]);
                    if (r_step == 2'd0) begin
                        r_state <= DONE;
                    end else begin
                        r_step <= r_step - 2'd1;
                    end
                end
                DONE: begin
                    r_value       <= r_acc;
                    r_frame_err   <= |r_err_slot;
                    r_changed     <= r_first | (r_acc != r_value);
                    r_first       <= 1'b0;
                    r_frame_valid <= 1'b1;
                    r_mask        <= 4'b0000;
                    r_state       <= COLLECT;
                end
                default: begin
                    r_state <= COLLECT;
                    r_mask  <= 4'b0000;
                end
            endcase
        end
    end

    assign value       = r_value;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign changed     = r_changed;
    assign bad_sel_cnt = r_bad_cnt;

    // Blank is accepted as digit 0; the flag itself is not needed further.
    logic w_unused;
    assign w_unused = w_blank;

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the multiplexed 7-segment digit encoder. Samples the scanned segment/digit-select bus (active-low segments, one-hot digit select), decodes each segment pattern back to a BCD digit, collects one complete 4-digit frame, and converts it to a binary value. It sits on the readback/self-check path next to the display driver, so the DPWM control logic and the bench can confirm what the display is showing.

## Interface
- No parameters; widths are fixed by the display bus.
- `clk_d`  in  1  display scan clock; all logic on its rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `sample_en`  in  1  sample the bus this cycle.
- `seg_in`  in  7  segment pattern, active-low, bit6=a … bit0=g.
- `dig_in`  in  4  digit select, one-hot; 0001=units, 0010=tens, 0100=hundreds, 1000=thousands.
- `clear`  in  1  synchronous; discards the partial frame.
- `value`  out  14  last decoded frame, binary, 0–9999.
- `frame_valid`  out  1  one-cycle pulse when `value` updates.
- `frame_err`  out  1  last frame contained an undecodable pattern.
- `changed`  out  1  last frame value differs from the previous frame.
- `bad_sel_cnt`  out  8  count of rejected samples with a non-one-hot `dig_in`; saturates at 255.

## Operation
- Pattern table (active-low, a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111.
- Blank decodes as digit 0 and is not an error. Any other pattern decodes as 0 and sets that digit's error bit.
- States:
  - COLLECT (reset state). On `sample_en` with a one-hot `dig_in`: store the decoded digit and error bit in the selected slot and set that slot's mask bit. A repeat of an already-captured position overwrites the slot.
  - COLLECT → CONVERT when the mask becomes 1111.
  - CONVERT: 4 cycles, MSB first, acc = acc*10 + digit. Uses shift-add (acc<<3 + acc<<1); no multiplier. acc is 14 bits and cannot overflow.
  - CONVERT → DONE. DONE writes `value` and `frame_err` (OR of the slot error bits), pulses `frame_valid`, clears the mask, and returns to COLLECT.
- Samples are ignored in CONVERT and DONE.
- Non-one-hot `dig_in` (including 0000) with `sample_en`: sample dropped, `bad_sel_cnt` +1 with saturation, mask unchanged. Counted in every state.
- `clear` in COLLECT: mask cleared. `clear` in CONVERT/DONE: ignored; the frame completes.
- `changed` updates at DONE. It is 1 if the new value differs from the previous `value`. The first frame after reset always gives `changed`=1.
- Reset values: state COLLECT, mask 0, `value` 0, `frame_valid` 0, `frame_err` 0, `changed` 0, `bad_sel_cnt` 0.
- Reset asserted mid-frame or mid-conversion: everything returns to reset values immediately, and the partial frame is lost.

## Timing
- Edge k accepts the sample that completes the mask.
- Edges k+1..k+4: CONVERT.
- Edge k+5: DONE. `value`, `frame_err` and `changed` are registered, and `frame_valid` is high for exactly the cycle after edge k+5.
- The first sample of the next frame can be accepted at edge k+6.
- Minimum frame period: 4 samples + 5 cycles.
- Outputs hold between frames.

## Structure
- Package `seg7_pkg`: the ten digit patterns and `SEG_BLANK`; the one-hot select constants `DIG_UNITS/TENS/HUNDREDS/THOUSANDS`; the state enum (COLLECT, CONVERT, DONE).
- The encoder side imports the same package so both ends share one table.
- Sub-module `seg7_pattern_decode`, combinational: `seg_in` → {bcd[3:0], blank, err}. Instantiated once, on the sampled bus.

## Test plan
- Scan units=0000001, tens=0100100, hundreds=0010010, thousands=1111111 → `value`=250, `frame_err`=0, `changed`=1, with `frame_valid` 5 edges after the 4th sample.
- Scan the order thousands=1001111, hundreds=0000001, tens=0000001, units=0000001 → `value`=1000. Repeat the same frame → `value`=1000, `changed`=0.
- Tens=1010101 with the other digits 0000001 → `value`=0, `frame_err`=1. The next clean frame clears `frame_err`.
- `dig_in`=0011 and 0000 with `sample_en` → mask unchanged, `bad_sel_cnt`=2. Drive 300 bad samples → `bad_sel_cnt` holds at 255.
- Three digits captured, then `clear`, then four digits of 0750 → `value`=750, and only one `frame_valid` pulse.
- `reset_n` low during CONVERT → all outputs 0 asynchronously, with no `frame_valid` after release. The next full frame decodes normally.
